detector_scheduler: RTL

DETECTOR_SCHEDULER -- requirements
Module: detector_scheduler

---
 rtl/detector_scheduler_pkg.sv | 21 ++
 rtl/pattern_shifter.sv | 44 ++++
 rtl/detector_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/detector_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : detector_scheduler_pkg
// Description : Shared state encoding and default sizes for the scheduler.
// Revision    : 1.0
// ============================================================================
package detector_scheduler_pkg;

    localparam int c_PAT_W_DEFAULT = 32;
    localparam int c_CNT_W_DEFAULT = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pattern_shifter
// Description : MSB-first parallel-to-serial shifter with a bit-index counter.
// Revision    : 1.0
// ============================================================================
module pattern_shifter
    import detector_scheduler_pkg::*;
#(
    parameter int PAT_W = c_PAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] data,
    input  logic             shift_en,
    output logic             sout,
    output logic             last
);

    localparam int                 c_IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0]   r_sreg;
    logic [c_IDX_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (load) begin
            r_sreg <= data;
            r_idx  <= '0;
        end else if (shift_en) begin
            r_sreg <= r_sreg << 1;
            r_idx  <= r_idx + c_IDX_W'(1);
        end
    end

    assign sout = r_sreg[PAT_W-1];
    assign last = (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/detector_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : detector_scheduler
// Description : Round-robin arbiter that streams a requester's pattern into a
//               shared serial detector and tallies the detector outputs.
// Revision    : 1.0
// ============================================================================
module detector_scheduler
    import detector_scheduler_pkg::*;
#(
    parameter int PAT_W = c_PAT_W_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [PAT_W-1:0] data0,
    input  logic [PAT_W-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             det_rst,
    output logic             det_x,
    input  logic [1:0]       det_y,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic             done,
    output logic             done_id,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state;
    logic             r_last;
    logic             r_first;
    logic             r_det_rst;
    logic             r_done_id;
    logic [CNT_W-1:0] r_cnt1;
    logic [CNT_W-1:0] r_cnt2;
    logic [CNT_W-1:0] r_cnt3;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_grant;
    logic [PAT_W-1:0] w_load_data;
    logic             w_shift_en;
    logic             w_sout;
    logic             w_last;
    logic             w_sample;

    // Grant is decided combinationally in IDLE so the grant cycle itself is
    // the data-sampling cycle; gating with rst keeps it quiet during reset.
    assign w_idle      = rst && (r_state == ST_IDLE);
    assign w_gnt0      = w_idle && req0 && (!req1 || r_last);
    assign w_gnt1      = w_idle && req1 && (!req0 || !r_last);
    assign w_grant     = w_gnt0 || w_gnt1;
    assign w_load_data = w_gnt1 ? data1 : data0;
    assign w_shift_en  = (r_state == ST_SHIFT);

    pattern_shifter #(
        .PAT_W (PAT_W)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_grant),
        .data     (w_load_data),
        .shift_en (w_shift_en),
        .sout     (w_sout),
        .last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_first   <= 1'b0;
            r_det_rst <= 1'b1;
            r_done_id <= 1'b0;
        end else begin
            r_det_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state   <= ST_CLR;
                        r_det_rst <= 1'b1;
                        r_done_id <= w_gnt1;
                        r_last    <= w_gnt1;
                    end
                end
                ST_CLR: begin
                    r_state <= ST_SHIFT;
                    r_first <= 1'b1;
                end
                ST_SHIFT: begin
                    r_first <= 1'b0;
                    if (w_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // The detector output lags det_x by one cycle, so the first SHIFT cycle
    // carries no result and DRAIN carries the last bit's result.
    assign w_sample = ((r_state == ST_SHIFT) && !r_first) || (r_state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst || (r_state == ST_CLR)) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
            r_cnt3 <= '0;
        end else if (w_sample) begin
            case (det_y)
                2'd1: if (r_cnt1 != c_CNT_MAX) r_cnt1 <= r_cnt1 + CNT_W'(1);
                2'd2: if (r_cnt2 != c_CNT_MAX) r_cnt2 <= r_cnt2 + CNT_W'(1);
                2'd3: if (r_cnt3 != c_CNT_MAX) r_cnt3 <= r_cnt3 + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign det_rst = r_det_rst;
    assign det_x   = w_shift_en && w_sout;
    assign cnt1    = r_cnt1;
    assign cnt2    = r_cnt2;
    assign cnt3    = r_cnt3;
    assign done    = (r_state == ST_DONE);
    assign done_id = r_done_id;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire
